// File: rtl/fib_index_if.sv
// Start/done handshake bundle for the inverse-Fibonacci search unit.
interface fib_index_if;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [4:0]  index;

  modport master (output start, value, input busy, done, found, index);
  modport slave  (input start, value, output busy, done, found, index);
endinterface

// File: rtl/fib_index.sv
// Inverse Fibonacci: walks f(k) upward from f(0) until it meets or passes the
// latched target, reporting the first such k and whether it was an exact hit.
module fib_index (
  input  logic        clk,
  input  logic        reset,
  fib_index_if.slave  bus
);

  typedef enum logic {S_IDLE, S_SEARCH} state_e;

  state_e      state_q, state_d;
  logic [15:0] tgt_q, tgt_d;
  logic [16:0] a_q, a_d;
  logic [16:0] b_q, b_d;
  logic [4:0]  k_q, k_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic [4:0]  index_q, index_d;

  logic [16:0] tgt_ext;
  logic        hit, past;

  assign tgt_ext = {1'b0, tgt_q};
  assign hit     = (a_q == tgt_ext);
  assign past    = (a_q > tgt_ext);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SEARCH;
      S_SEARCH: if (hit || past) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // f(25) exceeds any 16-bit target, so k stops at 25 and a+b stays in 17 bits.
  always_comb begin
    tgt_d   = tgt_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    found_d = found_q;
    index_d = index_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tgt_d  = bus.value;
          a_d    = 17'd0;
          b_d    = 17'd1;
          k_d    = 5'd0;
          busy_d = 1'b1;
        end
      end
      S_SEARCH: begin
        if (hit || past) begin
          found_d = hit;
          index_d = k_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          a_d = b_q;
          b_d = a_q + b_q;
          k_d = k_q + 5'd1;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.found = found_q;
  assign bus.index = index_q;

endmodule

// File: tb/tb_fib_index.sv
// Directed and random checks of fib_index against a plain Fibonacci-walk model.
module tb_fib_index;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  fib_index_if bus();

  fib_index dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Smallest n with f(n) >= v; exact hit means v is Fibonacci.
  task automatic model(input int v, output int f, output int idx);
    int x, y, t;
    x = 0; y = 1; idx = 0;
    while (x < v) begin
      t = x + y; x = y; y = t; idx++;
    end
    f = (x == v) ? 1 : 0;
  endtask

  // Called at a negedge; raises start so the next posedge is E0. Returns at
  // the negedge where done is seen, with start already low.
  task automatic search(input int v, input bit disturb, input string tag);
    int lat, ef, ei;
    model(v, ef, ei);
    bus.start = 1'b1;
    bus.value = v[15:0];
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, ".busy_up"}, int'(bus.busy), 1);
    lat = 0;
    do begin
      if (disturb) begin
        bus.start = lat[0];
        bus.value = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 40);
    bus.start = 1'b0;
    chk({tag, ".done"},    int'(bus.done),  1);
    chk({tag, ".found"},   int'(bus.found), ef);
    chk({tag, ".index"},   int'(bus.index), ei);
    chk({tag, ".latency"}, lat,             ei + 1);
    chk({tag, ".busy_dn"}, int'(bus.busy),  0);
  endtask

  task automatic quiet(input string tag);
    @(negedge clk);
    chk({tag, ".done_pulse"}, int'(bus.done), 0);
  endtask

  initial begin
    int fibs[$];
    int x, y, t, v, dones;
    bus.start = 1'b0;
    bus.value = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.busy",  int'(bus.busy),  0);
    chk("rst.done",  int'(bus.done),  0);
    chk("rst.found", int'(bus.found), 0);
    chk("rst.index", int'(bus.index), 0);
    reset = 1'b0;
    @(negedge clk);

    search(0, 1'b0, "v0");         quiet("v0");
    search(1, 1'b0, "v1");         quiet("v1");
    search(13, 1'b0, "v13");       quiet("v13");
    search(4, 1'b0, "v4");         quiet("v4");
    search(46368, 1'b0, "v46368"); quiet("v46368");
    search(65535, 1'b0, "v65535"); quiet("v65535");

    // Interference while busy, then back-to-back start in the done cycle.
    search(55, 1'b1, "v55");
    search(8, 1'b0, "v8_b2b");
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("b2b.extra_done", dones, 0);

    // Mid-search reset aborts immediately.
    bus.start = 1'b1;
    bus.value = 16'd46368;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort.busy",  int'(bus.busy),  0);
    chk("abort.done",  int'(bus.done),  0);
    chk("abort.found", int'(bus.found), 0);
    chk("abort.index", int'(bus.index), 0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    chk("abort.no_done", dones, 0);
    search(2, 1'b0, "v2"); quiet("v2");

    // Random: arbitrary values plus Fibonacci numbers and their neighbours.
    x = 0; y = 1;
    while (x <= 65535) begin
      fibs.push_back(x);
      t = x + y; x = y; y = t;
    end
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       v = int'($urandom_range(0, 65535));
        1:       v = fibs[$urandom_range(0, fibs.size() - 1)];
        default: v = fibs[$urandom_range(1, fibs.size() - 1)] + int'($urandom_range(0, 2)) - 1;
      endcase
      if (v > 65535) v = 65535;
      search(v, i[0], $sformatf("rnd%0d_v%0d", i, v));
      if ($urandom_range(0, 1) == 0) quiet("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
